// File: rtl/mmcm_phase_arbiter_if.sv
// rtl/mmcm_phase_arbiter_if.sv - absolute-phase port between the arbiter and mmcm_phase_cntr
//
// Purpose: carries the ps_we/ps_din/ps_ready/ps_dout handshake of one
// mmcm_phase_cntr absolute-phase port.
// Signals:
//   ps_we     write strobe, one cycle per phase request
//   ps_din    requested absolute phase (2's complement)
//   ps_ready  counter idle and locked; drops one cycle after ps_we
//   ps_dout   current phase of the counter
// Modports: master = arbiter side, slave = phase counter side.

interface mmcm_phase_arbiter_if #(
  parameter int PHASE_WIDTH = 8
);
  logic                   ps_we;
  logic [PHASE_WIDTH-1:0] ps_din;
  logic                   ps_ready;
  logic [PHASE_WIDTH-1:0] ps_dout;

  modport master (
    output ps_we,
    output ps_din,
    input  ps_ready,
    input  ps_dout
  );

  modport slave (
    input  ps_we,
    input  ps_din,
    output ps_ready,
    output ps_dout
  );
endinterface

// File: rtl/mmcm_phase_arbiter.sv
// rtl/mmcm_phase_arbiter.sv - round-robin arbiter for one mmcm_phase_cntr phase port
//
// Purpose: shares the absolute-phase port of mmcm_phase_cntr among NUM_REQ
// requesters, sequences the ps_we/ps_ready handshake and returns a one-cycle
// done pulse to the requester that was served. Lives in the psclk domain.
// Optional feature: define MMCM_PHASE_ARBITER_TIMEOUT_EN to add the timeout
// output and a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
// Ports:
//   psclk      clock (same as mmcm_phase_cntr psclk)
//   rst        synchronous active-high reset
//   req        per-requester request level, held until its done pulse
//   req_phase  flattened target phases, requester i at [i*PHASE_WIDTH +: PHASE_WIDTH]
//   done       one-hot completion pulse
//   busy       operation in progress
//   owner      index of the last granted requester
//   cur_phase  ps_dout captured at completion
//   timeout    (optional) pulses with done when WAIT gave up
//   ps         master side of the phase-counter port (ps_we/ps_din/ps_ready/ps_dout)

module mmcm_phase_arbiter #(
  parameter int PHASE_WIDTH    = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           psclk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PHASE_WIDTH-1:0] req_phase,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [2:0]                     owner,
  output logic [PHASE_WIDTH-1:0]         cur_phase,
`ifdef MMCM_PHASE_ARBITER_TIMEOUT_EN
  output logic                           timeout,
`endif
  mmcm_phase_arbiter_if.master           ps
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mmcm_phase_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state;
  logic [2:0] rr;
  logic [2:0] sel;

`ifdef MMCM_PHASE_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Rotating search starting at rr. Walking the offsets downward lets the
  // smallest offset with req set overwrite the others, i.e. win.
  always_comb begin
    sel = rr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr) + k) % NUM_REQ]) begin
        sel = 3'((int'(rr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge psclk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr        <= 3'd0;
      done      <= '0;
      busy      <= 1'b0;
      owner     <= 3'd0;
      ps.ps_we  <= 1'b0;
      ps.ps_din <= '0;
      cur_phase <= '0;
`ifdef MMCM_PHASE_ARBITER_TIMEOUT_EN
      timeout   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      done     <= '0;
      ps.ps_we <= 1'b0;
`ifdef MMCM_PHASE_ARBITER_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // ps_ready low means the MMCM is unlocked or settling; requests
          // simply stay pending until it rises.
          if (|req && ps.ps_ready) begin
            owner     <= sel;
            ps.ps_din <= req_phase[int'(sel)*PHASE_WIDTH +: PHASE_WIDTH];
            ps.ps_we  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_GUARD;
        end
        S_GUARD: begin
          // ps_ready seen here still reflects the pre-write counter state.
          state <= S_WAIT;
`ifdef MMCM_PHASE_ARBITER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (ps.ps_ready) begin
            done  <= ONE << owner;
            state <= S_DONE;
          end
`ifdef MMCM_PHASE_ARBITER_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            done    <= ONE << owner;
            timeout <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
`ifdef MMCM_PHASE_ARBITER_TIMEOUT_EN
          // A timed-out move never settled, so ps_dout is not trustworthy.
          if (!timeout) begin
            cur_phase <= ps.ps_dout;
          end
`else
          cur_phase <= ps.ps_dout;
`endif
          rr    <= (int'(owner) == NUM_REQ - 1) ? 3'd0 : owner + 3'd1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mmcm_phase_arbiter.md
Name: mmcm_phase_arbiter

Overview:
Round-robin arbiter that shares one mmcm_phase_cntr absolute-phase port among NUM_REQ requesters (e.g. DQS/DQ phase scan, write-leveling, host register writes).
It sequences the ps_we/ps_din/ps_ready handshake and owns the single write path into the phase counter.
It returns a per-requester completion pulse and reports the last granted owner.
It sits in the psclk domain directly in front of mmcm_phase_cntr.

Parameters:
PHASE_WIDTH, 8, width of the phase value; must match mmcm_phase_cntr.
NUM_REQ, 4, number of requesters, 2..8.
TIMEOUT_CYCLES, 1024, WAIT-state cycle limit; used only with the optional feature.

Ports:
psclk  in  1  clock; same clock as mmcm_phase_cntr psclk.
rst  in  1  reset; synchronous, active-high, sampled on posedge psclk.
req  in  NUM_REQ  per-requester request level; held until matching done.
req_phase  in  NUM_REQ*PHASE_WIDTH  flattened target phases; requester i uses bits [i*PHASE_WIDTH +: PHASE_WIDTH]; 2's complement.
done  out  NUM_REQ  one-cycle completion pulse, one-hot.
busy  out  1  an operation is in progress (state != IDLE).
owner  out  3  index of the last granted requester.
ps_we  out  1  to mmcm_phase_cntr ps_we.
ps_din  out  PHASE_WIDTH  to mmcm_phase_cntr ps_din.
ps_ready  in  1  from mmcm_phase_cntr ps_ready.
ps_dout  in  PHASE_WIDTH  from mmcm_phase_cntr; current phase.
cur_phase  out  PHASE_WIDTH  ps_dout registered at completion.

Behaviour:
- Reset values:
  - done=0, busy=0, owner=0, ps_we=0, ps_din=0, cur_phase=0.
  - Round-robin pointer rr=0, state=IDLE.
- States: IDLE -> ISSUE -> GUARD -> WAIT -> DONE -> IDLE.
- IDLE
  - Leaves IDLE only when |req && ps_ready.
  - Selects the first requester with req set, searching from rr upward and wrapping modulo NUM_REQ.
  - Registers owner=sel and ps_din=req_phase[sel]; next state ISSUE.
  - If ps_ready=0 (MMCM unlocked or still settling), stays in IDLE; requests are not lost.
- ISSUE
  - ps_we=1 for exactly one cycle.
  - ps_din is held stable from ISSUE through DONE.
- GUARD
  - One cycle with no checks.
  - The downstream ps_ready drops one cycle after ps_we. ps_ready sampled in ISSUE or GUARD is stale and is ignored.
- WAIT
  - Stays until ps_ready=1, then goes to DONE.
  - There is no other exit unless the optional feature is enabled.
- DONE
  - done[owner]=1 for one cycle; cur_phase<=ps_dout; rr<=(owner+1) mod NUM_REQ.
  - Next state IDLE.
- Latency:
  - If the requested phase equals the current phase, done asserts 4 cycles after the IDLE grant.
  - Otherwise latency is 4 cycles plus the MMCM step time (|delta| steps of about 12 psclk each).
- Fairness: a requester that keeps req high is served at most once per round while any other requester waits.
- Back-to-back: IDLE may grant again on the cycle after DONE. A requester whose req is still high after its done pulse counts as a new request.
- Request dropped mid-operation: the operation completes and the done pulse is still issued. req_phase changes after the grant are ignored.
- Simultaneous requests: resolved by rr only; no fixed priority.
- Reset mid-operation: all state and outputs return to reset values on the next edge. No done pulse is issued for the aborted operation. A new grant waits for ps_ready.
- busy is a registered decode of state.

Optional Feature:
- Macro: MMCM_PHASE_ARBITER_TIMEOUT_EN.
- When defined:
  - Adds output timeout (1 bit, reset 0) and a WAIT-state cycle counter; the counter clears on entry to WAIT.
  - If the counter reaches TIMEOUT_CYCLES before ps_ready=1, the FSM goes to DONE.
  - In that DONE cycle, done[owner] pulses together with timeout=1, and cur_phase is not updated.
- When undefined:
  - The timeout port and counter are absent.
  - WAIT waits indefinitely.

Test Plan:
1. Single request: req=0001, req_phase[0]=8'h05, ps_ready idle-high model -> exactly one ps_we pulse with ps_din=05; done=0001 after the model finishes; cur_phase=05; owner=0.
2. Same phase: request phase 00 while ps_dout=00 -> done pulse exactly 4 cycles after the grant; one ps_we pulse.
3. Round-robin: req=1111 held continuously -> grant order 0,1,2,3,0; never two consecutive grants to the same index.
4. Unlocked: ps_ready=0 with req=0010 -> no ps_we and busy stays 0; after ps_ready rises, the grant follows on the next cycle.
5. Reset mid-WAIT: rst high 1 cycle while in WAIT -> busy=0, done=0, ps_we=0, owner=0 next cycle; no done pulse for the aborted request.
6. With MMCM_PHASE_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, ps_ready stuck low after the grant -> done[owner] together with timeout=1 about 16 cycles into WAIT; cur_phase unchanged.
